// File: rtl/ni_param.sv
// rtl/ni_param.sv - GPU<->router network interface for the AI-Grid NoC leaf
//
// Purpose:
//   TX path: takes GPU flits {dest_id, payload}, checks the destination ID, and
//   rewrites the header as the routing address (dest_id + ADDR_OFFSET). Illegal
//   IDs are consumed and flagged on err_dest. Flits are buffered in a FIFO and
//   presented to the router through a registered output stage.
//   RX path: takes router flits, keeps those whose header is this leaf's routing
//   address, and rewrites the header back to GPU_ID. Other flits are consumed,
//   dropped and counted in a saturating counter.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   gpu_data_in/valid/ready    TX stream from the GPU
//   router_data_out/valid/rdy  TX stream to the router
//   router_data_in/valid/rdy   RX stream from the router
//   gpu_data_out/valid/ready   RX stream to the GPU
//   err_dest                   one-cycle pulse per discarded illegal-ID TX flit
//   drop_count                 saturating count of dropped misrouted RX flits
//
// Configuration:
//   LOOPBACK_EN  when defined, a TX flit addressed to GPU_ID is written straight
//                into the RX FIFO instead of being sent to the router.

module ni_param_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle,
  // which keeps the ready outputs independent of the downstream handshake.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: nothing reads an entry before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module ni_param_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_take,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  // Reload whenever the stage is empty or its flit leaves this cycle, so a
  // continuous stream moves one flit per cycle.
  assign in_take = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_take) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

module ni_param #(
  parameter int GPU_ID      = 16,
  parameter int NUM_GPUS    = 32,
  parameter int DATA_W      = 16,
  parameter int HDR_W       = 6,
  parameter int ADDR_OFFSET = 3,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] gpu_data_in,
  input  logic              gpu_valid_in,
  output logic              gpu_ready_out,
  output logic [DATA_W-1:0] gpu_data_out,
  output logic              gpu_valid_out,
  input  logic              gpu_ready_in,
  output logic [DATA_W-1:0] router_data_out,
  output logic              router_valid_out,
  input  logic              router_ready_in,
  input  logic [DATA_W-1:0] router_data_in,
  input  logic              router_valid_in,
  output logic              router_ready_out,
  output logic              err_dest,
  output logic [CNT_W-1:0]  drop_count
);
  localparam int PL_W = DATA_W - HDR_W;
  localparam logic [HDR_W-1:0] MAX_ID    = HDR_W'(NUM_GPUS);
  localparam logic [HDR_W-1:0] SELF_ID   = HDR_W'(GPU_ID);
  localparam logic [HDR_W-1:0] OFFSET    = HDR_W'(ADDR_OFFSET);
  localparam logic [HDR_W-1:0] SELF_ADDR = HDR_W'(GPU_ID + ADDR_OFFSET);

  // ---------------- TX: GPU -> router ----------------
  logic [HDR_W-1:0]  tx_id;
  logic [PL_W-1:0]   tx_pl;
  logic              tx_legal;
  logic              tx_accept;
  logic              tx_push;
  logic [DATA_W-1:0] tx_push_data;
  logic [DATA_W-1:0] tx_head;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_pop;
  logic              lb_push;

  // ---------------- RX: router -> GPU ----------------
  logic [HDR_W-1:0]  rx_hdr;
  logic [PL_W-1:0]   rx_pl;
  logic              rx_accept;
  logic              rx_match;
  logic              router_push;
  logic              rx_push;
  logic [DATA_W-1:0] rx_push_data;
  logic [DATA_W-1:0] rx_head;
  logic              rx_empty;
  logic              rx_full;
  logic              rx_pop;

  assign tx_id    = gpu_data_in[DATA_W-1 -: HDR_W];
  assign tx_pl    = gpu_data_in[PL_W-1:0];
  assign tx_legal = (tx_id != '0) && (tx_id <= MAX_ID);

`ifdef LOOPBACK_EN
  logic tx_self;
  assign tx_self = (tx_id == SELF_ID);
  // The router owns the RX FIFO write port; a self-addressed flit waits while
  // the router is offering a flit or the RX FIFO has no room.
  assign gpu_ready_out = tx_self ? (!rx_full && !router_valid_in) : !tx_full;
  assign lb_push       = gpu_valid_in && gpu_ready_out && tx_self;
`else
  assign gpu_ready_out = !tx_full;
  assign lb_push       = 1'b0;
`endif

  assign tx_accept    = gpu_valid_in && gpu_ready_out;
  assign tx_push      = tx_accept && tx_legal && !lb_push;
  assign tx_push_data = {tx_id + OFFSET, tx_pl};

  ni_param_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  ni_param_stage #(.W(DATA_W)) u_tx_stage (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (!tx_empty),
    .in_data   (tx_head),
    .in_take   (tx_pop),
    .out_data  (router_data_out),
    .out_valid (router_valid_out),
    .out_ready (router_ready_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_dest <= 1'b0;
    else       err_dest <= tx_accept && !tx_legal;
  end

  assign rx_hdr           = router_data_in[DATA_W-1 -: HDR_W];
  assign rx_pl            = router_data_in[PL_W-1:0];
  assign router_ready_out = !rx_full;
  assign rx_accept        = router_valid_in && router_ready_out;
  assign rx_match         = (rx_hdr == SELF_ADDR);
  assign router_push      = rx_accept && rx_match;
  assign rx_push          = router_push || lb_push;
  assign rx_push_data     = router_push ? {SELF_ID, rx_pl} : {SELF_ID, tx_pl};

  ni_param_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  ni_param_stage #(.W(DATA_W)) u_rx_stage (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (!rx_empty),
    .in_data   (rx_head),
    .in_take   (rx_pop),
    .out_data  (gpu_data_out),
    .out_valid (gpu_valid_out),
    .out_ready (gpu_ready_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (rx_accept && !rx_match && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ni_param.sv
// tb/tb_ni_param.sv - directed self-checking bench for ni_param

module tb_ni_param;
  logic        clk;
  logic        reset;
  logic [15:0] gpu_data_in;
  logic        gpu_valid_in;
  logic        gpu_ready_out;
  logic [15:0] gpu_data_out;
  logic        gpu_valid_out;
  logic        gpu_ready_in;
  logic [15:0] router_data_out;
  logic        router_valid_out;
  logic        router_ready_in;
  logic [15:0] router_data_in;
  logic        router_valid_in;
  logic        router_ready_out;
  logic        err_dest;
  logic [7:0]  drop_count;

  int vectors;
  int miscompares;
  int rx_idx;

  ni_param #(
    .GPU_ID(16), .NUM_GPUS(32), .DATA_W(16), .HDR_W(6),
    .ADDR_OFFSET(3), .DEPTH(8), .CNT_W(8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .gpu_data_in      (gpu_data_in),
    .gpu_valid_in     (gpu_valid_in),
    .gpu_ready_out    (gpu_ready_out),
    .gpu_data_out     (gpu_data_out),
    .gpu_valid_out    (gpu_valid_out),
    .gpu_ready_in     (gpu_ready_in),
    .router_data_out  (router_data_out),
    .router_valid_out (router_valid_out),
    .router_ready_in  (router_ready_in),
    .router_data_in   (router_data_in),
    .router_valid_in  (router_valid_in),
    .router_ready_out (router_ready_out),
    .err_dest         (err_dest),
    .drop_count       (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rvalid"}, router_valid_out, 1'b0);
    check({tag, "_gvalid"}, gpu_valid_out, 1'b0);
    check({tag, "_rdata"}, router_data_out, 16'h0000);
    check({tag, "_gdata"}, gpu_data_out, 16'h0000);
    check({tag, "_err"}, err_dest, 1'b0);
    check({tag, "_drop"}, drop_count, 8'd0);
    check({tag, "_gready"}, gpu_ready_out, 1'b1);
    check({tag, "_rready"}, router_ready_out, 1'b1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    gpu_data_in = '0;
    gpu_valid_in = 1'b0;
    gpu_ready_in = 1'b1;
    router_ready_in = 1'b1;
    router_data_in = '0;
    router_valid_in = 1'b0;

    repeat (3) tick();
    check_idle("reset");
    reset = 1'b0;
    tick();

    // TX dest 5 -> route 8: 0x1555 -> 0x2155, visible after the second edge, one cycle
    gpu_data_in = 16'h1555;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    check("tx_lat1", router_valid_out, 1'b0);
    tick();
    check("tx_valid", router_valid_out, 1'b1);
    check("tx_data", router_data_out, 16'h2155);
    tick();
    check("tx_one_cycle", router_valid_out, 1'b0);

    // RX hdr 19 -> id 16; hdr 20 dropped
    router_data_in = 16'h4CAA;
    router_valid_in = 1'b1;
    tick();
    router_valid_in = 1'b0;
    check("rx_lat1", gpu_valid_out, 1'b0);
    tick();
    check("rx_valid", gpu_valid_out, 1'b1);
    check("rx_data", gpu_data_out, 16'h40AA);
    tick();
    check("rx_one_cycle", gpu_valid_out, 1'b0);
    router_data_in = 16'h50AA;
    router_valid_in = 1'b1;
    tick();
    router_valid_in = 1'b0;
    tick();
    check("rx_drop_valid", gpu_valid_out, 1'b0);
    check("rx_drop_count", drop_count, 8'd1);

    // Illegal dest 0 and 33
    gpu_data_in = 16'h0155;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    check("err0_pulse", err_dest, 1'b1);
    tick();
    check("err0_clear", err_dest, 1'b0);
    check("err0_rvalid", router_valid_out, 1'b0);
    gpu_data_in = 16'h8555;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    check("err33_pulse", err_dest, 1'b1);
    tick();
    check("err33_clear", err_dest, 1'b0);
    check("err33_rvalid", router_valid_out, 1'b0);

    // Legal boundaries: dest 32 -> route 35 (0x8D55), dest 1 -> route 4 (0x1155)
    gpu_data_in = 16'h8155;
    gpu_valid_in = 1'b1;
    tick();
    gpu_data_in = 16'h0555;
    check("err32_none", err_dest, 1'b0);
    tick();
    gpu_valid_in = 1'b0;
    check("dest32_data", router_data_out, 16'h8D55);
    check("err1_none", err_dest, 1'b0);
    tick();
    check("dest1_data", router_data_out, 16'h1155);
    check("dest1_valid", router_valid_out, 1'b1);
    tick();

    // Fill: stage holds the first flit, FIFO the next 8 -> ready drops after 9
    router_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      gpu_data_in = 16'h0400 | 16'(i);
      gpu_valid_in = 1'b1;
      check("fill_ready", gpu_ready_out, 1'b1);
      tick();
    end
    check("full_ready", gpu_ready_out, 1'b0);
    gpu_data_in = 16'h0409;
    repeat (3) begin
      tick();
      check("stall_valid", router_valid_out, 1'b1);
      check("stall_data", router_data_out, 16'h1000);
    end
    gpu_valid_in = 1'b0;
    router_ready_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("drain_valid", router_valid_out, 1'b1);
      check("drain_data", router_data_out, 16'h1000 | 16'(i));
      tick();
    end
    check("drain_end", router_valid_out, 1'b0);

    // Drop counter saturates at 255
    router_data_in = 16'h50AA;
    router_valid_in = 1'b1;
    repeat (260) tick();
    router_valid_in = 1'b0;
    check("drop_sat", drop_count, 8'hFF);
    check("drop_sat_gvalid", gpu_valid_out, 1'b0);

    // Continuous stream of 20 flits (pointers wrap twice)
    rx_idx = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        gpu_data_in = 16'h0440 | 16'(c);
        gpu_valid_in = 1'b1;
      end else begin
        gpu_valid_in = 1'b0;
      end
      tick();
      if (router_valid_out) begin
        check("stream_data", router_data_out, 16'h1040 | 16'(rx_idx));
        rx_idx++;
      end
    end
    check("stream_count", rx_idx, 20);

    // Reset mid-burst with both directions holding flits
    router_ready_in = 1'b0;
    gpu_ready_in = 1'b0;
    gpu_valid_in = 1'b1;
    router_valid_in = 1'b1;
    router_data_in = 16'h4C11;
    for (int i = 0; i < 4; i++) begin
      gpu_data_in = 16'h0400 | 16'(i);
      tick();
    end
    gpu_valid_in = 1'b0;
    router_valid_in = 1'b0;
    check("pre_rst_rvalid", router_valid_out, 1'b1);
    check("pre_rst_gvalid", gpu_valid_out, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("midrst");
    tick();
    reset = 1'b0;
    router_ready_in = 1'b1;
    gpu_ready_in = 1'b1;
    repeat (3) begin
      tick();
      check("postrst_rvalid", router_valid_out, 1'b0);
      check("postrst_gvalid", gpu_valid_out, 1'b0);
    end

    // Self-addressed flit 0x4001 (dest 16)
    gpu_data_in = 16'h4001;
    gpu_valid_in = 1'b1;
    tick();
    gpu_valid_in = 1'b0;
    tick();
`ifdef LOOPBACK_EN
    check("lb_gvalid", gpu_valid_out, 1'b1);
    check("lb_gdata", gpu_data_out, 16'h4001);
    check("lb_rvalid", router_valid_out, 1'b0);
    tick();
    check("lb_done", gpu_valid_out, 1'b0);

    // Router flit wins the RX FIFO; loopback flit follows
    gpu_data_in = 16'h4001;
    gpu_valid_in = 1'b1;
    router_data_in = 16'h4CAA;
    router_valid_in = 1'b1;
    #1;
    check("lb_blocked", gpu_ready_out, 1'b0);
    tick();
    router_valid_in = 1'b0;
    #1;
    check("lb_unblocked", gpu_ready_out, 1'b1);
    tick();
    gpu_valid_in = 1'b0;
    check("lb_first", gpu_data_out, 16'h40AA);
    check("lb_first_v", gpu_valid_out, 1'b1);
    tick();
    check("lb_second", gpu_data_out, 16'h4001);
    check("lb_second_v", gpu_valid_out, 1'b1);
    check("lb_second_r", router_valid_out, 1'b0);
    tick();
`else
    check("self_rvalid", router_valid_out, 1'b1);
    check("self_rdata", router_data_out, 16'h4C01);
    check("self_gvalid", gpu_valid_out, 1'b0);
    tick();
    check("self_done", router_valid_out, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
